// File: rtl/vga_pkg.sv
// Shared definitions for the VGA framebuffer write scheduler.
//   color_t      : 2-bit pixel codes
//   Default*     : default frame geometry and coordinate widths
//   fill_state_e : states of the fill sequencer
package vga_pkg;

  typedef enum logic [1:0] {
    BLACK = 2'd0,
    WHITE = 2'd1,
    BLUE  = 2'd2,
    GREEN = 2'd3
  } color_t;

  localparam int unsigned DefaultHd    = 1280;
  localparam int unsigned DefaultVd    = 1024;
  localparam int unsigned DefaultXBits = 11;
  localparam int unsigned DefaultYBits = 11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StDone = 2'd2
  } fill_state_e;

endpackage

// File: rtl/vga_rr_arbiter.sv
// Round-robin arbiter with an internal last-grant pointer.
//   clk_i, arst_i : clock, asynchronous active-high reset
//   valid_i       : request vector (already masked by the caller when arbitration is off)
//   advance_i     : a grant was taken this cycle; move the pointer to the granted index
//   grant_o       : one-hot grant, search starts at (last_grant + 1) mod N_REQ
module vga_rr_arbiter #(
  parameter int unsigned N_REQ = 2
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [N_REQ-1:0] valid_i,
  input  logic             advance_i,
  output logic [N_REQ-1:0] grant_o
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] grant_idx;

  always_comb begin
    logic            found;
    int unsigned     idx;
    logic [IdxW-1:0] idx_w;
    grant_o   = '0;
    grant_idx = ptr_q;
    found     = 1'b0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx   = (32'(ptr_q) + i) % N_REQ;
      idx_w = IdxW'(idx);
      if (!found && valid_i[idx_w]) begin
        found          = 1'b1;
        grant_o[idx_w] = 1'b1;
        grant_idx      = idx_w;
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= grant_idx;
    end
  end

endmodule

// File: rtl/vga_fb_write_sched.sv
// Write-port scheduler for the VGA framebuffer: round-robin sharing of the single
// write port between N_REQ pixel requesters, plus a full-frame fill sequencer.
//   clk_i, arst_i             : pixel clock, asynchronous active-high reset
//   req_valid_i/req_ready_o   : per-requester handshake (ready is one-hot or zero)
//   req_x_i/req_y_i/req_color_i : packed per-requester coordinates and pixel codes
//   fill_start_i/fill_color_i : start a frame fill with the given colour
//   fill_busy_o/fill_done_o   : fill in progress / one-cycle completion pulse
//   vblank_i                  : vertical blanking, only used with VGA_FB_VBLANK_ONLY_EN
//   fb_we_o/fb_x_o/fb_y_o/fb_color_o : registered framebuffer write port
//   drop_o                    : accepted request was out of range and discarded
// Build option: define VGA_FB_VBLANK_ONLY_EN to restrict all writes to vertical blanking.
module vga_fb_write_sched
  import vga_pkg::*;
#(
  parameter int unsigned HD      = DefaultHd,
  parameter int unsigned VD      = DefaultVd,
  parameter int unsigned X_BITS  = DefaultXBits,
  parameter int unsigned Y_BITS  = DefaultYBits,
  parameter int unsigned COLOR_W = 2,
  parameter int unsigned N_REQ   = 2
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic [N_REQ*X_BITS-1:0]  req_x_i,
  input  logic [N_REQ*Y_BITS-1:0]  req_y_i,
  input  logic [N_REQ*COLOR_W-1:0] req_color_i,
  input  logic                     fill_start_i,
  input  logic [COLOR_W-1:0]       fill_color_i,
  output logic                     fill_busy_o,
  output logic                     fill_done_o,
  input  logic                     vblank_i,
  output logic                     fb_we_o,
  output logic [X_BITS-1:0]        fb_x_o,
  output logic [Y_BITS-1:0]        fb_y_o,
  output logic [COLOR_W-1:0]       fb_color_o,
  output logic                     drop_o
);

  localparam logic [X_BITS-1:0] XLast = X_BITS'(HD - 1);
  localparam logic [Y_BITS-1:0] YLast = Y_BITS'(VD - 1);

  fill_state_e state_q, state_d;

  // The write-address registers double as the fill sweep counters.
  logic               fb_we_q, fb_we_d;
  logic [X_BITS-1:0]  fb_x_q, fb_x_d;
  logic [Y_BITS-1:0]  fb_y_q, fb_y_d;
  logic [COLOR_W-1:0] fb_color_q, fb_color_d;
  logic               drop_q, drop_d;

  logic               arb_en;
  logic               fill_step;
  logic [N_REQ-1:0]   grant;
  logic               xfer;
  logic [X_BITS-1:0]  sel_x;
  logic [Y_BITS-1:0]  sel_y;
  logic [COLOR_W-1:0] sel_color;
  logic               in_range;

`ifdef VGA_FB_VBLANK_ONLY_EN
  assign arb_en    = (state_q == StIdle) && !fill_start_i && vblank_i;
  assign fill_step = vblank_i;
  // Fill keeps we registered high; blanking gates the actual strobe.
  assign fb_we_o   = fb_we_q && ((state_q != StFill) || vblank_i);
`else
  logic unused_vblank;
  assign unused_vblank = vblank_i;
  assign arb_en        = (state_q == StIdle) && !fill_start_i;
  assign fill_step     = 1'b1;
  assign fb_we_o       = fb_we_q;
`endif

  vga_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arbiter (
    .clk_i     (clk_i),
    .arst_i    (arst_i),
    .valid_i   (req_valid_i & {N_REQ{arb_en}}),
    .advance_i (xfer),
    .grant_o   (grant)
  );

  assign req_ready_o = grant;
  assign xfer        = |(req_valid_i & grant);

  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    sel_color = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        sel_x     = req_x_i[k*X_BITS +: X_BITS];
        sel_y     = req_y_i[k*Y_BITS +: Y_BITS];
        sel_color = req_color_i[k*COLOR_W +: COLOR_W];
      end
    end
  end

  assign in_range = (32'(sel_x) < HD) && (32'(sel_y) < VD);

  always_comb begin
    state_d    = state_q;
    fb_we_d    = 1'b0;
    fb_x_d     = fb_x_q;
    fb_y_d     = fb_y_q;
    fb_color_d = fb_color_q;
    drop_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fill_start_i) begin
          state_d    = StFill;
          fb_we_d    = 1'b1;
          fb_x_d     = '0;
          fb_y_d     = '0;
          fb_color_d = fill_color_i;
        end else if (xfer) begin
          fb_x_d     = sel_x;
          fb_y_d     = sel_y;
          fb_color_d = sel_color;
          fb_we_d    = in_range;
          drop_d     = !in_range;
        end
      end
      StFill: begin
        fb_we_d = 1'b1;
        if (fill_step) begin
          if (fb_x_q == XLast) begin
            fb_x_d = '0;
            if (fb_y_q == YLast) begin
              state_d = StDone;
              fb_we_d = 1'b0;
              fb_y_d  = '0;
            end else begin
              fb_y_d = fb_y_q + 1'b1;
            end
          end else begin
            fb_x_d = fb_x_q + 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= StIdle;
      fb_we_q    <= 1'b0;
      fb_x_q     <= '0;
      fb_y_q     <= '0;
      fb_color_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fb_we_q    <= fb_we_d;
      fb_x_q     <= fb_x_d;
      fb_y_q     <= fb_y_d;
      fb_color_q <= fb_color_d;
      drop_q     <= drop_d;
    end
  end

  assign fb_x_o      = fb_x_q;
  assign fb_y_o      = fb_y_q;
  assign fb_color_o  = fb_color_q;
  assign drop_o      = drop_q;
  assign fill_busy_o = (state_q == StFill);
  assign fill_done_o = (state_q == StDone);

endmodule

// File: tb/tb_vga_fb_write_sched.sv
module tb_vga_fb_write_sched;
  import vga_pkg::*;

  localparam int unsigned HD = 8;
  localparam int unsigned VD = 4;
  localparam int unsigned XB = 11;
  localparam int unsigned YB = 11;
  localparam int unsigned CW = 2;
  localparam int unsigned NR = 2;

  logic            clk = 1'b0;
  logic            arst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*XB-1:0] req_x;
  logic [NR*YB-1:0] req_y;
  logic [NR*CW-1:0] req_color;
  logic            fill_start;
  logic [CW-1:0]   fill_color;
  logic            fill_busy;
  logic            fill_done;
  logic            vblank;
  logic            fb_we;
  logic [XB-1:0]   fb_x;
  logic [YB-1:0]   fb_y;
  logic [CW-1:0]   fb_color;
  logic            drop;

  always #5 clk = ~clk;

  vga_fb_write_sched #(
    .HD(HD), .VD(VD), .X_BITS(XB), .Y_BITS(YB), .COLOR_W(CW), .N_REQ(NR)
  ) dut (
    .clk_i       (clk),
    .arst_i      (arst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_x_i     (req_x),
    .req_y_i     (req_y),
    .req_color_i (req_color),
    .fill_start_i(fill_start),
    .fill_color_i(fill_color),
    .fill_busy_o (fill_busy),
    .fill_done_o (fill_done),
    .vblank_i    (vblank),
    .fb_we_o     (fb_we),
    .fb_x_o      (fb_x),
    .fb_y_o      (fb_y),
    .fb_color_o  (fb_color),
    .drop_o      (drop)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [10:0] x0, y0;
    logic [1:0]  c0;
    logic [10:0] x1, y1;
    logic [1:0]  c1;
    logic [1:0]  ready;
    logic        we;
    logic [10:0] ex, ey;
    logic [1:0]  ec;
    logic        drop;
  } vec_t;

  typedef struct {
    logic        we;
    logic [10:0] x, y;
    logic [1:0]  c;
    logic        drop;
  } exp_t;

  localparam int NV = 15;
  vec_t vecs[NV];
  exp_t sb[$];

  function automatic vec_t mk(input logic [1:0] valid,
                              input int x0, input int y0, input int c0,
                              input int x1, input int y1, input int c1,
                              input logic [1:0] ready, input logic we,
                              input int ex, input int ey, input int ec, input logic dr);
    vec_t v;
    v.valid = valid;
    v.x0 = 11'(x0); v.y0 = 11'(y0); v.c0 = 2'(c0);
    v.x1 = 11'(x1); v.y1 = 11'(y1); v.c1 = 2'(c1);
    v.ready = ready; v.we = we;
    v.ex = 11'(ex); v.ey = 11'(ey); v.ec = 2'(ec); v.drop = dr;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_we"}, fb_we, 0);
    check({tag, "_x"}, fb_x, 0);
    check({tag, "_y"}, fb_y, 0);
    check({tag, "_color"}, fb_color, 0);
    check({tag, "_drop"}, drop, 0);
    check({tag, "_busy"}, fill_busy, 0);
    check({tag, "_done"}, fill_done, 0);
    check({tag, "_ready"}, req_ready, 0);
  endtask

  initial begin
    exp_t e;
    int   done_cnt;
    int   we_cnt;

    // Pointer starts at 0, so the search begins at requester 1.
    vecs[0]  = mk(2'b00, 0, 0, 0, 0, 0, 0,    2'b00, 0, 0, 0, 0, 0);
    vecs[1]  = mk(2'b01, 1, 1, 1, 0, 0, 0,    2'b01, 1, 1, 1, 1, 0);
    vecs[2]  = mk(2'b11, 2, 0, 2, 6, 3, 3,    2'b10, 1, 6, 3, 3, 0);
    vecs[3]  = mk(2'b11, 4, 2, 1, 7, 1, 0,    2'b01, 1, 4, 2, 1, 0);
    vecs[4]  = mk(2'b11, 0, 0, 3, 1, 3, 2,    2'b10, 1, 1, 3, 2, 0);
    vecs[5]  = mk(2'b11, 5, 1, 0, 2, 2, 1,    2'b01, 1, 5, 1, 0, 0);
    vecs[6]  = mk(2'b01, 6, 2, 2, 0, 0, 0,    2'b01, 1, 6, 2, 2, 0);
    vecs[7]  = mk(2'b01, 7, 3, 3, 0, 0, 0,    2'b01, 1, 7, 3, 3, 0);
    vecs[8]  = mk(2'b10, 0, 0, 0, 3, 0, 1,    2'b10, 1, 3, 0, 1, 0);
    vecs[9]  = mk(2'b01, 8, 5, 1, 0, 0, 0,    2'b01, 0, 0, 0, 0, 1);
    vecs[10] = mk(2'b10, 0, 0, 0, 2, 4, 1,    2'b10, 0, 0, 0, 0, 1);
    vecs[11] = mk(2'b01, 1280, 5, 1, 0, 0, 0, 2'b01, 0, 0, 0, 0, 1);
    vecs[12] = mk(2'b01, 7, 0, 2, 0, 0, 0,    2'b01, 1, 7, 0, 2, 0);
    vecs[13] = mk(2'b10, 0, 0, 0, 0, 3, 3,    2'b10, 1, 0, 3, 3, 0);
    vecs[14] = mk(2'b00, 0, 0, 0, 0, 0, 0,    2'b00, 0, 0, 0, 0, 0);

    arst = 1'b1;
    req_valid = '0; req_x = '0; req_y = '0; req_color = '0;
    fill_start = 1'b0; fill_color = '0; vblank = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    arst = 1'b0;
    tick();

    // Table-driven request vectors through the scoreboard.
    for (int i = 0; i < NV; i++) begin
      req_valid = vecs[i].valid;
      req_x     = {vecs[i].x1, vecs[i].x0};
      req_y     = {vecs[i].y1, vecs[i].y0};
      req_color = {vecs[i].c1, vecs[i].c0};
      #1;
      check($sformatf("ready_v%0d", i), req_ready, vecs[i].ready);
      sb.push_back('{vecs[i].we, vecs[i].ex, vecs[i].ey, vecs[i].ec, vecs[i].drop});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("we_v%0d", i), fb_we, e.we);
      check($sformatf("drop_v%0d", i), drop, e.drop);
      if (e.we) begin
        check($sformatf("x_v%0d", i), fb_x, e.x);
        check($sformatf("y_v%0d", i), fb_y, e.y);
        check($sformatf("color_v%0d", i), fb_color, e.c);
      end
    end
    req_valid = '0;

    // Collision: fill wins, pending request waits through the whole sweep.
    fill_start = 1'b1;
    fill_color = BLUE;
    req_valid  = 2'b01;
    req_x = {11'd0, 11'd2};
    req_y = {11'd0, 11'd1};
    req_color = {2'd0, 2'd1};
    #1;
    check("collision_ready", req_ready, 2'b00);
    @(posedge clk);
    #1;
    fill_start = 1'b0;
    for (int i = 0; i < int'(HD * VD); i++) begin
      if (i == 5) begin
        fill_start = 1'b1;
        fill_color = GREEN;
      end else begin
        fill_start = 1'b0;
      end
      #1;
      check($sformatf("fill_we_%0d", i), fb_we, 1);
      check($sformatf("fill_x_%0d", i), fb_x, i % HD);
      check($sformatf("fill_y_%0d", i), fb_y, i / HD);
      check($sformatf("fill_color_%0d", i), fb_color, BLUE);
      check($sformatf("fill_busy_%0d", i), fill_busy, 1);
      check($sformatf("fill_ready_%0d", i), req_ready, 0);
      check($sformatf("fill_done_%0d", i), fill_done, 0);
      tick();
    end
    fill_start = 1'b0;
    check("done_pulse", fill_done, 1);
    check("done_we", fb_we, 0);
    check("done_busy", fill_busy, 0);
    check("done_ready", req_ready, 0);
    tick();
    check("idle_done_low", fill_done, 0);
    check("post_fill_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    check("post_fill_we", fb_we, 1);
    check("post_fill_x", fb_x, 2);
    check("post_fill_y", fb_y, 1);
    check("post_fill_color", fb_color, 1);

    // Move the pointer to requester 1 so the reset of it is observable.
    req_valid = 2'b10;
    req_x = {11'd3, 11'd0};
    req_y = {11'd2, 11'd0};
    req_color = {2'd3, 2'd0};
    #1;
    check("pre_reset_ready", req_ready, 2'b10);
    tick();
    req_valid = '0;
    check("pre_reset_we", fb_we, 1);

    // Reset in the middle of a sweep.
    fill_start = 1'b1;
    fill_color = BLUE;
    tick();
    fill_start = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      check($sformatf("abort_sweep_x_%0d", i), fb_x, i % HD);
      if (i < 10) tick();
    end
    arst = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    tick();
    check_outputs_zero("reset_edge");
    arst = 1'b0;
    done_cnt = 0;
    we_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (fill_done) done_cnt++;
      if (fb_we || fill_busy) we_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_no_activity", we_cnt, 0);
    req_valid = 2'b11;
    req_x = {11'd4, 11'd1};
    req_y = {11'd0, 11'd0};
    req_color = {2'd2, 2'd1};
    #1;
    check("ptr_reset_ready", req_ready, 2'b10);
    tick();
    req_valid = '0;
    check("ptr_reset_x", fb_x, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fb_write_sched.md
Name: vga_fb_write_sched

Overview:
- Schedules the single write port of the VGA framebuffer (2-bit pixel codes, HD x VD).
- Shares the port round-robin between N_REQ pixel-write requesters using valid/ready handshakes.
- Contains a fill sequencer that sweeps the whole frame with one colour (screen clear).
- Sits between the pixel sources (host, drawing engines) and the framebuffer's we/addr_x/addr_y/color write inputs.

Parameters:
- HD, 1280, horizontal display pixels.
- VD, 1024, vertical display lines.
- X_BITS, 11, x coordinate width; must satisfy 2**X_BITS >= HD.
- Y_BITS, 11, y coordinate width; must satisfy 2**Y_BITS >= VD.
- COLOR_W, 2, pixel code width.
- N_REQ, 2, number of requesters; range 2..8.

Ports:
- clk_i  in  1  pixel clock.
- arst_i  in  1  reset; asynchronous, active-high.
- req_valid_i  in  N_REQ  per-requester write request.
- req_ready_o  out  N_REQ  per-requester accept; at most one bit set.
- req_x_i  in  N_REQ*X_BITS  packed x coordinates; requester k at [k*X_BITS +: X_BITS].
- req_y_i  in  N_REQ*Y_BITS  packed y coordinates.
- req_color_i  in  N_REQ*COLOR_W  packed pixel codes.
- fill_start_i  in  1  start a full-frame fill.
- fill_color_i  in  COLOR_W  fill pixel code; sampled with fill_start_i.
- fill_busy_o  out  1  fill in progress.
- fill_done_o  out  1  one-cycle pulse when a fill completes.
- vblank_i  in  1  vertical blanking from the timing generator; used only with the optional feature.
- fb_we_o  out  1  framebuffer write enable.
- fb_x_o  out  X_BITS  write x address.
- fb_y_o  out  Y_BITS  write y address.
- fb_color_o  out  COLOR_W  write pixel code.
- drop_o  out  1  one-cycle pulse: an accepted request was out of range and discarded.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, fill counters 0.
- Reset asserted mid-fill aborts the fill. No fill_done_o pulse is produced.
- States:
  - IDLE: arbitrate requesters.
  - FILL: sweep the frame.
  - DONE: single cycle; fill_done_o=1.
- IDLE -> FILL when fill_start_i=1. Latch fill_color_i; x_cnt=0, y_cnt=0.
- FILL -> DONE after the write to (HD-1, VD-1).
- DONE -> IDLE unconditionally.
- fill_start_i is ignored in FILL and DONE.
- Arbitration (IDLE only, fill_start_i=0):
  - Round-robin search starts at (last_grant+1) mod N_REQ.
  - The first requester with valid set gets req_ready_o (combinational from valid, state and fill_start_i).
  - Transfer = valid && ready, at most one per cycle.
  - last_grant updates only on a transfer.
- fill_start_i=1 in IDLE forces req_ready_o=0 that cycle; the fill wins.
- req_ready_o=0 in FILL and DONE. Pending requests wait; do not drop valid.
- Write latency: fb_* registered; fb_we_o=1 the cycle after a transfer, carrying that transfer's x/y/colour.
- Range check: a transfer with x>=HD or y>=VD is consumed but not written. fb_we_o stays 0; drop_o=1 the following cycle.
- Fill write order: x inner (0..HD-1), then y (0..VD-1). One write per cycle, fb_we_o=1 continuously for HD*VD cycles.
- fill_busy_o=1 from the cycle after fill_start_i through the last fill write.
- fb_we_o=0 in DONE.
- Counters compare with ==HD-1 / ==VD-1; no reliance on power-of-two wrap.

Optional Feature:
- Macro: VGA_FB_VBLANK_ONLY_EN.
- When defined:
  - req_ready_o is additionally gated by vblank_i.
  - FILL writes only on cycles with vblank_i=1. Counters hold and fb_we_o=0 otherwise.
  - fill_busy_o stays high across frames until the sweep completes.
- When undefined: vblank_i is unused; behaviour exactly as above.

Decomposition:
- Shared package vga_pkg:
  - color_t enum: BLACK=0, WHITE=1, BLUE=2, GREEN=3.
  - Default HD/VD/X_BITS/Y_BITS constants.
  - fill FSM state enum.
- Sub-module vga_rr_arbiter (N_REQ):
  - Inputs: valid vector, advance strobe.
  - Output: one-hot grant.
  - Holds the pointer internally.

Test Plan:
- Reset mid-fill: HD=8, VD=4, fill_start_i with colour BLUE; arst_i pulse at sweep cycle 10 -> all outputs 0 next edge, no fill_done_o, state IDLE.
- Fill sweep: HD=8, VD=4, fill_start_i with colour BLUE:
  - fb_we_o high 32 consecutive cycles, addresses (0,0),(1,0)..(7,3), fb_color_o=2.
  - fill_done_o pulses once, one cycle after the (7,3) write.
- Round-robin fairness: both requesters valid continuously -> grants alternate 0,1,0,1.
  - Next cycle fb_we_o=1 with the matching coordinates.
  - Requester 1 drops valid -> requester 0 granted every cycle.
- Collision: fill_start_i and req_valid_i[0] in the same cycle -> req_ready_o=0.
  - Request accepted on the first IDLE cycle after fill_done_o.
- Out of range: req x=HD (1280), y=5 -> ready=1, fb_we_o stays 0, drop_o pulses one cycle later.
  - Next valid request is written normally.
- VGA_FB_VBLANK_ONLY_EN defined, vblank_i low -> req_ready_o=0.
  - vblank_i=1 for 3 cycles during a fill -> exactly 3 writes, counters frozen outside.
